pgcb_burst_sched: RTL and testbench

//   Shares one pulse-generator/counter chain between NREQ requesters.

---
 rtl/pgcb_burst_sched_if.sv | 29 ++
 rtl/pgcb_burst_sched.sv | 169 ++++++++++++++++
 tb/tb_pgcb_burst_sched.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pgcb_burst_sched_if.sv
// Bundle between the burst scheduler, its requesters (req/len/gnt/done/err/busy/pcnt)
// and the shared pulse-generator/counter chain (pg_trg/pg_rdy/pg_pout).
interface pgcb_burst_sched_if #(
   parameter int unsigned NREQ   = 4,
   parameter int unsigned LEN_W  = 8,
   parameter int unsigned PCNT_W = 8
);
   logic [NREQ-1:0]       req;
   logic [NREQ*LEN_W-1:0] len;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       done;
   logic                  err;
   logic                  busy;
   logic [PCNT_W-1:0]     pcnt;
   logic                  pg_trg;
   logic                  pg_rdy;
   logic                  pg_pout;

   // master: requesters plus the chain; slave: the scheduler
   modport master (
      output req, len, pg_rdy, pg_pout,
      input  gnt, done, err, busy, pcnt, pg_trg
   );

   modport slave (
      input  req, len, pg_rdy, pg_pout,
      output gnt, done, err, busy, pcnt, pg_trg
   );
endinterface

// File: rtl/pgcb_burst_sched.sv
// Round-robin burst scheduler sharing one PGCB trigger chain between NREQ requesters.
// Define PGCB_SCHED_ABORT_EN to let a granted requester end its burst early by dropping REQ.
module pgcb_burst_sched #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned LEN_W   = 8,
   parameter int unsigned TIMEOUT = 1000,
   parameter int unsigned PCNT_W  = 8
) (
   input logic               clk,
   input logic               r_n,
   pgcb_burst_sched_if.slave bus
);
   localparam int unsigned      PTR_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned      TMR_W    = $clog2(TIMEOUT + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NREQ - 1);

   typedef enum logic [2:0] {IDLE, GRANT, FIRE, WAIT, FIN} state_t;

   state_t            state_q, state_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [PTR_W-1:0]  rr_q, rr_d;
   logic [LEN_W-1:0]  rem_q, len_win;
   logic [TMR_W-1:0]  timer_q;
   logic [PCNT_W-1:0] pcnt_q;
   logic              trg_q, tmo_q, rdy_q, pout_q;
   logic              rdy_rise, pout_rise;
   logic              win_vld;
   logic [PTR_W-1:0]  win, cand;
   int unsigned       idx;
   logic              do_grant, do_fire, do_dec, do_tmo;
   logic              stop_after_shot;

   assign rdy_rise  = bus.pg_rdy  & ~rdy_q;
   assign pout_rise = bus.pg_pout & ~pout_q;

   // First set request at or above the rr pointer, wrapping once around
   always_comb begin
      win_vld = 1'b0;
      win     = '0;
      idx     = 0;
      cand    = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = 32'(rr_q) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         cand = PTR_W'(idx);
         if (!win_vld && bus.req[cand]) begin
            win_vld = 1'b1;
            win     = cand;
         end
      end
   end

   always_comb begin
      gnt_d   = '0;
      len_win = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (PTR_W'(k) == win) begin
            gnt_d[k] = 1'b1;
            len_win  = bus.len[k*LEN_W +: LEN_W];
         end
      end
      rr_d = (win == PTR_LAST) ? '0 : win + 1'b1;
   end

`ifdef PGCB_SCHED_ABORT_EN
   logic own_req, abort_q;

   assign own_req         = |(bus.req & gnt_q);
   // A drop seen at any point in WAIT ends the burst once the shot in flight returns
   assign stop_after_shot = abort_q | ~own_req;

   always_ff @(posedge clk or negedge r_n) begin
      if (!r_n) begin
         abort_q <= 1'b0;
      end else if (do_grant) begin
         abort_q <= 1'b0;
      end else if (state_q == WAIT && !own_req) begin
         abort_q <= 1'b1;
      end
   end
`else
   assign stop_after_shot = 1'b0;
`endif

   always_ff @(posedge clk or negedge r_n) begin
      if (!r_n) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      do_grant = 1'b0;
      do_fire  = 1'b0;
      do_dec   = 1'b0;
      do_tmo   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (win_vld) begin
               do_grant = 1'b1;
               state_d  = GRANT;
            end
         end
         GRANT: state_d = (rem_q == '0) ? FIN : FIRE;
         FIRE: begin
`ifdef PGCB_SCHED_ABORT_EN
            if (!own_req) begin
               state_d = FIN;
            end else
`endif
            if (bus.pg_rdy) begin
               do_fire = 1'b1;
               state_d = WAIT;
            end
         end
         WAIT: begin
            // A returning shot wins over a timeout landing in the same cycle
            if (rdy_rise) begin
               do_dec  = 1'b1;
               state_d = (rem_q == LEN_W'(1) || stop_after_shot) ? FIN : FIRE;
            end else if (timer_q == TMR_LAST) begin
               do_tmo  = 1'b1;
               state_d = FIN;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge r_n) begin
      if (!r_n) begin
         gnt_q   <= '0;
         rr_q    <= '0;
         rem_q   <= '0;
         timer_q <= '0;
         pcnt_q  <= '0;
         trg_q   <= 1'b0;
         tmo_q   <= 1'b0;
         rdy_q   <= 1'b0;
         pout_q  <= 1'b0;
      end else begin
         rdy_q  <= bus.pg_rdy;
         pout_q <= bus.pg_pout;
         trg_q  <= do_fire;
         if (do_grant) begin
            gnt_q  <= gnt_d;
            rem_q  <= len_win;
            rr_q   <= rr_d;
            pcnt_q <= '0;
            tmo_q  <= 1'b0;
         end else begin
            if (state_q == FIN) gnt_q <= '0;
            if (do_dec)         rem_q <= rem_q - 1'b1;
            if (do_tmo)         tmo_q <= 1'b1;
            if (state_q != IDLE && pout_rise && pcnt_q != '1) pcnt_q <= pcnt_q + 1'b1;
         end
         if (do_fire)              timer_q <= '0;
         else if (state_q == WAIT) timer_q <= timer_q + 1'b1;
      end
   end

   assign bus.gnt    = gnt_q;
   assign bus.busy   = (state_q != IDLE);
   assign bus.done   = (state_q == FIN) ? gnt_q : '0;
   assign bus.err    = (state_q == FIN) & tmo_q;
   assign bus.pcnt   = pcnt_q;
   assign bus.pg_trg = trg_q;
endmodule

// File: tb/tb_pgcb_burst_sched.sv
// Randomized bench for pgcb_burst_sched: a behavioural chain model drives pg_rdy/pg_pout,
// and a round-robin/burst reference model predicts grants, shot counts, DONE/ERR and PCNT.
module tb_pgcb_burst_sched;
   localparam int NREQ    = 4;
   localparam int LEN_W   = 8;
   localparam int TIMEOUT = 1000;
   localparam int PCNT_W  = 8;

   logic clk = 1'b0;
   logic r_n = 1'b0;
   always #5 clk = ~clk;

   pgcb_burst_sched_if #(.NREQ(NREQ), .LEN_W(LEN_W), .PCNT_W(PCNT_W)) bus ();

   pgcb_burst_sched #(
      .NREQ(NREQ), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT), .PCNT_W(PCNT_W)
   ) dut (
      .clk(clk),
      .r_n(r_n),
      .bus(bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Observation state, written by the monitor at posedge+1
   int         cyc = 0;
   int         trg_cnt = 0, done_seen = 0, err_cnt = 0;
   int         last_trg_cyc = 0, first_trg_cyc = 0, done_cyc = 0;
   logic [3:0] done_val = '0;
   logic       err_val = 1'b0;
   logic       prev_trg = 1'b0;
   logic [3:0] prev_gnt = '0;
   int         grant_log[$];

   // Chain model controls
   int stuck_shot = 0, shot_no = 0, pulse_total = 0;
   int pmin = 0, pmax = 2;
   int chain_np = 0, chain_lo = 0;
   bit release_rdy = 1'b0;

   // Reference model state
   int model_rr = 0;
   int lens[NREQ];
   int n_tmo = 0;

   function automatic int pick(input logic [3:0] rq, input int rr);
      for (int k = 0; k < NREQ; k++) begin
         if (((rq >> ((rr + k) % NREQ)) & 4'd1) != 4'd0) return (rr + k) % NREQ;
      end
      return 0;
   endfunction

   function automatic int sat(input int v);
      return (v > 255) ? 255 : v;
   endfunction

   initial begin
      forever begin
         @(posedge clk); #1;
         cyc++;
         if (bus.pg_trg === 1'b1) begin
            check_eq("trg_gap", 64'(prev_trg), 64'd0);
            if (trg_cnt == 0) first_trg_cyc = cyc;
            trg_cnt++;
            last_trg_cyc = cyc;
         end
         if (bus.done !== 4'b0) begin
            done_seen++;
            done_val = bus.done;
            err_val  = bus.err;
            done_cyc = cyc;
         end
         if (bus.err === 1'b1) begin
            err_cnt++;
            check_eq("err_with_done", 64'(|bus.done), 64'd1);
         end
         if (bus.gnt !== prev_gnt && bus.gnt !== 4'b0) begin
            check_eq("gnt_onehot", 64'($onehot(bus.gnt)), 64'd1);
            check_eq("gnt_gap", 64'(prev_gnt), 64'd0);
            for (int k = 0; k < NREQ; k++)
               if (bus.gnt == 4'(1 << k)) grant_log.push_back(k);
         end
         prev_trg = bus.pg_trg;
         prev_gnt = bus.gnt;
      end
   end

   // Chain: drops ready on a trigger, emits some pulses, returns ready unless told to hang
   initial begin
      bus.pg_rdy  = 1'b1;
      bus.pg_pout = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (bus.pg_trg === 1'b1) begin
            shot_no++;
            bus.pg_rdy = 1'b0;
            chain_np = int'($urandom_range(pmax, pmin));
            repeat (chain_np) begin
               @(posedge clk); #1; bus.pg_pout = 1'b1; pulse_total++;
               @(posedge clk); #1; bus.pg_pout = 1'b0;
            end
            if (shot_no == stuck_shot) begin
               while (!release_rdy) begin @(posedge clk); #1; end
            end else begin
               chain_lo = int'($urandom_range(4, 1));
               repeat (chain_lo) begin @(posedge clk); #1; end
            end
            bus.pg_rdy = 1'b1;
         end
      end
   end

   task automatic drive_req(input logic [3:0] rq);
      bus.req = rq;
      bus.len = {8'(lens[3]), 8'(lens[2]), 8'(lens[1]), 8'(lens[0])};
   endtask

   task automatic clear_obs(input int stuck);
      trg_cnt = 0; done_seen = 0; err_cnt = 0;
      shot_no = 0; pulse_total = 0; stuck_shot = stuck;
   endtask

   task automatic wait_done(input int budget);
      int b;
      b = budget;
      while (done_seen == 0 && b > 0) begin @(negedge clk); b--; end
      check_eq("done_in_time", 64'(done_seen != 0), 64'd1);
   endtask

   // stuck_sel: 0 = chain always returns, -1 = random hung shot, >0 = that shot hangs
   task automatic run_burst(input logic [3:0] rq, input int stuck_sel);
      int w, stuck, exp_shots, g_cyc;
      logic [3:0] exp_gnt;
      w       = pick(rq, model_rr);
      exp_gnt = 4'(1 << w);
      stuck   = 0;
      if (stuck_sel > 0 && stuck_sel <= lens[w]) stuck = stuck_sel;
      else if (stuck_sel < 0 && lens[w] > 0) stuck = int'($urandom_range(lens[w], 1));
      exp_shots = (stuck != 0) ? stuck : lens[w];
      clear_obs(stuck);
      @(negedge clk);
      drive_req(rq);
      @(negedge clk);
      g_cyc = cyc;
      check_eq("gnt", 64'(bus.gnt), 64'(exp_gnt));
      check_eq("busy", 64'(bus.busy), 64'd1);
      model_rr = (w + 1) % NREQ;
      wait_done(20 * lens[w] + ((stuck != 0) ? TIMEOUT : 0) + 40);
      check_eq("done_vec", 64'(done_val), 64'(exp_gnt));
      check_eq("err", 64'(err_val), 64'(stuck != 0));
      check_eq("shots", 64'(trg_cnt), 64'(exp_shots));
      if (exp_shots > 0) check_eq("first_trg_lat", 64'(first_trg_cyc - g_cyc), 64'd2);
      if (stuck != 0) check_eq("tmo_cycles", 64'(done_cyc - last_trg_cyc), 64'(TIMEOUT));
      bus.req = 4'b0;
      release_rdy = 1'b1;
      repeat (3) @(negedge clk);
      release_rdy = 1'b0;
      check_eq("done_once", 64'(done_seen), 64'd1);
      check_eq("err_cnt", 64'(err_cnt), 64'(stuck != 0));
      check_eq("pcnt", 64'(bus.pcnt), 64'(sat(pulse_total)));
      check_eq("idle_busy", 64'(bus.busy), 64'd0);
      check_eq("idle_gnt", 64'(bus.gnt), 64'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_gnt"},  64'(bus.gnt),    64'd0);
      check_eq({tag, "_done"}, 64'(bus.done),   64'd0);
      check_eq({tag, "_err"},  64'(bus.err),    64'd0);
      check_eq({tag, "_busy"}, 64'(bus.busy),   64'd0);
      check_eq({tag, "_pcnt"}, 64'(bus.pcnt),   64'd0);
      check_eq({tag, "_trg"},  64'(bus.pg_trg), 64'd0);
   endtask

   initial begin
      int b, w;
      bus.req = 4'b0;
      bus.len = '0;
      for (int k = 0; k < NREQ; k++) lens[k] = 0;
      repeat (3) @(negedge clk);
      check_all_zero("rst");
      r_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single requester, three shots, one pulse per shot
      pmin = 1; pmax = 1;
      lens[0] = 3;
      run_burst(4'b0001, 0);
      pmin = 0; pmax = 2;

      // Zero-length burst completes without triggering
      lens[2] = 0;
      run_burst(4'b0100, 0);

      // Hung chain on the first shot, then the other requester must win
      lens[0] = 3; lens[1] = 3;
      run_burst(4'b0011, 1);
      run_burst(4'b0011, 0);

      for (int i = 0; i < 30; i++) begin
         for (int k = 0; k < NREQ; k++) lens[k] = int'($urandom_range(6, 0));
         if (n_tmo < 2 && $urandom_range(9, 0) == 0) begin
            n_tmo++;
            run_burst(4'($urandom_range(15, 1)), -1);
         end else begin
            run_burst(4'($urandom_range(15, 1)), 0);
         end
      end

      // Pulse counter saturation
      pmin = 3; pmax = 3;
      lens[1] = 100;
      run_burst(4'b0010, 0);
      pmin = 0; pmax = 2;

      // Requester drops REQ after its second trigger
      lens[0] = 10;
      clear_obs(0);
      @(negedge clk);
      drive_req(4'b0001);
      model_rr = 1;
      b = 200;
      while (trg_cnt < 2 && b > 0) begin @(negedge clk); b--; end
      bus.req = 4'b0;
      wait_done(300);
`ifdef PGCB_SCHED_ABORT_EN
      check_eq("abort_shots", 64'(trg_cnt), 64'd2);
`else
      check_eq("abort_shots", 64'(trg_cnt), 64'd10);
`endif
      check_eq("abort_done", 64'(done_val), 64'd1);
      check_eq("abort_err", 64'(err_cnt), 64'd0);
      repeat (3) @(negedge clk);

      // Reset in the middle of a five-shot burst
      lens[0] = 5;
      clear_obs(0);
      @(negedge clk);
      drive_req(4'b0001);
      b = 200;
      while (trg_cnt < 2 && b > 0) begin @(negedge clk); b--; end
      check_eq("rst_mid_reached", 64'(trg_cnt), 64'd2);
      r_n = 1'b0;
      bus.req = 4'b0;
      #1;
      check_all_zero("rst_mid");
      repeat (2) @(negedge clk);
      r_n = 1'b1;
      repeat (20) @(negedge clk);
      check_eq("rst_no_done", 64'(done_seen), 64'd0);
      model_rr = 0;
      lens[0] = 2; lens[3] = 2;
      run_burst(4'b1001, 0);

      // All requesters held with unit bursts: grants rotate from a fresh pointer
      r_n = 1'b0;
      repeat (2) @(negedge clk);
      r_n = 1'b1;
      @(negedge clk);
      model_rr = 0;
      for (int k = 0; k < NREQ; k++) lens[k] = 1;
      clear_obs(0);
      grant_log.delete();
      drive_req(4'b1111);
      b = 400;
      while (grant_log.size() < 5 && b > 0) begin @(negedge clk); b--; end
      bus.req = 4'b0;
      b = 100;
      while (bus.busy !== 1'b0 && b > 0) begin @(negedge clk); b--; end
      repeat (3) @(negedge clk);
      check_eq("held_grants", 64'(grant_log.size()), 64'd5);
      for (int i = 0; i < 5; i++) begin
         w = pick(4'b1111, model_rr);
         model_rr = (w + 1) % NREQ;
         if (i < grant_log.size()) check_eq("held_order", 64'(grant_log[i]), 64'(w));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
